// File: rtl/calc_pkg.sv
// Shared encodings for the calculator sequencer: FSM states, ALU op codes,
// error codes and the display clamp used when chaining a result.
package calc_pkg;

  localparam logic [2:0] ST_ENTER_A = 3'd0;
  localparam logic [2:0] ST_ENTER_B = 3'd1;
  localparam logic [2:0] ST_SEL_OP  = 3'd2;
  localparam logic [2:0] ST_ISSUE   = 3'd3;
  localparam logic [2:0] ST_WAIT    = 3'd4;
  localparam logic [2:0] ST_SHOW    = 3'd5;
  localparam logic [2:0] ST_ERROR   = 3'd6;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ALU     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam int DISP_MAX = 999;

endpackage

// File: rtl/op_timeout_timer.sv
// Cycle counter bounding how long the sequencer waits on the ALU.
// expired flags the last allowed cycle while counting is enabled.
module op_timeout_timer #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign expired = en && (count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/calc_sequencer.sv
// Operand/operation sequencer: captures A and B, picks an op, runs the
// shared ALU through a start/done handshake and holds result or error.
module calc_sequencer #(
  parameter int DATA_W      = 16,
  parameter int RES_W       = 32,
  parameter int TIMEOUT_CYC = 1024,
  parameter int DISP_MAX    = calc_pkg::DISP_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              confirm,
  input  logic              op_next,
  input  logic              clear,
  input  logic [DATA_W-1:0] entry_data,
  output logic              entry_sel,
  output logic              alu_start,
  output logic              alu_abort,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic              alu_done,
  input  logic              alu_err,
  input  logic [RES_W-1:0]  alu_result,
  output logic [RES_W-1:0]  result,
  output logic              result_valid,
  output logic [1:0]        err_code,
  output logic [2:0]        state_out,
  output logic              busy
);

  import calc_pkg::*;

  localparam logic signed [RES_W-1:0] CLAMP_HI = RES_W'(DISP_MAX);
  localparam logic signed [RES_W-1:0] CLAMP_LO = -CLAMP_HI;

  logic [2:0]        state;
  logic              tmr_clr;
  logic              tmr_en;
  logic              expired;
  logic [DATA_W-1:0] chain_a;

  // Handshake: alu_start is a one-cycle strobe while in ISSUE; the ALU answers
  // with a one-cycle alu_done (qualified by alu_err) that is honoured only in
  // WAIT. Operands and op are frozen from ISSUE until WAIT is left.
  assign alu_start    = (state == ST_ISSUE);
  assign busy         = (state == ST_ISSUE) || (state == ST_WAIT);
  assign entry_sel    = (state == ST_ENTER_B);
  assign result_valid = (state == ST_SHOW);
  assign state_out    = state;

  // Timer is zeroed on the way into ISSUE so ISSUE itself is the first counted cycle.
  assign tmr_clr = (state == ST_SEL_OP) && confirm && !clear;
  assign tmr_en  = busy;

  op_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(expired)
  );

  always_comb begin
    chain_a = result[DATA_W-1:0];
    if ($signed(result) > CLAMP_HI) begin
      chain_a = CLAMP_HI[DATA_W-1:0];
    end else if ($signed(result) < CLAMP_LO) begin
      chain_a = CLAMP_LO[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_ENTER_A;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= OP_ADD;
      result    <= '0;
      err_code  <= ERR_NONE;
      alu_abort <= 1'b0;
    end else begin
      alu_abort <= clear && ((state == ST_ISSUE) || (state == ST_WAIT));
      if (clear) begin
        state    <= ST_ENTER_A;
        err_code <= ERR_NONE;
      end else begin
        case (state)
          ST_ENTER_A: if (confirm) begin
            alu_a <= entry_data;
            state <= ST_ENTER_B;
          end
          ST_ENTER_B: if (confirm) begin
            alu_b <= entry_data;
            state <= ST_SEL_OP;
          end
          ST_SEL_OP: begin
            if (confirm) begin
              state <= ST_ISSUE;
            end else if (op_next) begin
              alu_op <= alu_op + 2'd1;
            end
          end
          ST_ISSUE: state <= ST_WAIT;
          ST_WAIT: begin
            // A done arriving on the timeout cycle still counts as success.
            if (alu_done) begin
              if (alu_err) begin
                err_code <= ERR_ALU;
                state    <= ST_ERROR;
              end else begin
                result <= alu_result;
                state  <= ST_SHOW;
              end
            end else if (expired) begin
              err_code <= ERR_TIMEOUT;
              state    <= ST_ERROR;
            end
          end
          ST_SHOW: begin
            if (confirm) begin
              state <= ST_ENTER_A;
            end else if (op_next) begin
              alu_a <= chain_a;
              state <= ST_ENTER_B;
            end
          end
          ST_ERROR: if (confirm) begin
            err_code <= ERR_NONE;
            state    <= ST_ENTER_A;
          end
          default: state <= ST_ENTER_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed plus randomized bench for calc_sequencer with a small arithmetic
// reference model standing in for the expected ALU behaviour.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        confirm = 1'b0;
  logic        op_next = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] entry_data = '0;
  logic        entry_sel;
  logic        alu_start;
  logic        alu_abort;
  logic [1:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_done = 1'b0;
  logic        alu_err = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] result;
  logic        result_valid;
  logic [1:0]  err_code;
  logic [2:0]  state_out;
  logic        busy;

  int n_cmp = 0;
  int n_fail = 0;

  int          m_op = 0;
  logic [15:0] m_a = '0;
  logic [15:0] m_b = '0;
  logic [31:0] m_result = '0;

  calc_sequencer #(
    .DATA_W(16),
    .RES_W(32),
    .TIMEOUT_CYC(16),
    .DISP_MAX(999)
  ) dut (
    .clk(clk), .reset(reset), .confirm(confirm), .op_next(op_next),
    .clear(clear), .entry_data(entry_data), .entry_sel(entry_sel),
    .alu_start(alu_start), .alu_abort(alu_abort), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done), .alu_err(alu_err),
    .alu_result(alu_result), .result(result), .result_valid(result_valid),
    .err_code(err_code), .state_out(state_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input int op, input logic [15:0] a, input logic [15:0] b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    case (op)
      0: return 32'(sa + sb);
      1: return 32'(sa - sb);
      2: return 32'(sa * sb);
      default: return (sb == 0) ? 32'd0 : 32'(sa / sb);
    endcase
  endfunction

  function automatic logic [15:0] clamp_ref(input logic [31:0] r);
    int v = int'($signed(r));
    if (v > 999) v = 999;
    if (v < -999) v = -999;
    return 16'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_confirm();
    confirm = 1'b1; tick(); confirm = 1'b0;
  endtask

  task automatic pulse_op_next();
    op_next = 1'b1; tick(); op_next = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic enter_operands(input int a, input int b);
    entry_data = 16'(a);
    pulse_confirm();
    m_a = 16'(a);
    check("enter_b_state", 32'(state_out), 32'd1);
    check("enter_b_sel", 32'(entry_sel), 32'd1);
    entry_data = 16'(b);
    pulse_confirm();
    m_b = 16'(b);
    check("sel_op_state", 32'(state_out), 32'd2);
  endtask

  task automatic select_op(input int n);
    repeat (n) pulse_op_next();
    m_op = (m_op + n) % 4;
    check("sel_op_value", 32'(alu_op), 32'(m_op));
  endtask

  // Confirm in SEL_OP; the start strobe must appear on the very next cycle.
  task automatic issue();
    pulse_confirm();
    check("issue_start", 32'(alu_start), 32'd1);
    check("issue_state", 32'(state_out), 32'd3);
    check("issue_busy", 32'(busy), 32'd1);
    check("issue_a", 32'(alu_a), 32'(m_a));
    check("issue_b", 32'(alu_b), 32'(m_b));
    check("issue_op", 32'(alu_op), 32'(m_op));
  endtask

  task automatic respond(input int delay, input logic err, input logic [31:0] res);
    tick();
    check("wait_start_low", 32'(alu_start), 32'd0);
    check("wait_state", 32'(state_out), 32'd4);
    repeat (delay) tick();
    alu_done = 1'b1; alu_err = err; alu_result = res;
    tick();
    alu_done = 1'b0; alu_err = 1'b0; alu_result = $urandom();
  endtask

  initial begin
    int cycles;
    logic busy_prev;
    int a, b, n, new_op, dly;
    logic [31:0] r;

    // Reset state
    #2 reset = 1'b0;
    #2;
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_outs", {alu_start, alu_abort, entry_sel, result_valid, busy, err_code, alu_op}, 32'd0);
    check("rst_a_b", {alu_a, alu_b}, 32'd0);
    check("rst_result", result, 32'd0);
    tick(); tick();
    @(negedge clk) reset = 1'b1;
    tick();

    // Basic ADD: 25 + (-7)
    enter_operands(25, -7);
    check("add_b_raw", 32'(alu_b), 32'h0000_FFF9);
    select_op(0);
    issue();
    r = alu_ref(m_op, m_a, m_b);
    respond(2, 1'b0, r);
    check("add_result", result, 32'd18);
    check("add_valid", 32'(result_valid), 32'd1);
    check("add_state", 32'(state_out), 32'd5);
    check("add_busy", 32'(busy), 32'd0);
    pulse_confirm();
    check("show_confirm_state", 32'(state_out), 32'd0);

    // Op wrap: five op_next pulses from ADD land on SUB
    enter_operands(10, 3);
    select_op(5);
    check("wrap_is_sub", 32'(alu_op), 32'd1);
    issue();
    respond(1, 1'b0, alu_ref(m_op, m_a, m_b));
    check("sub_result", result, 32'd7);
    pulse_confirm();

    // Divide by zero reported by the ALU
    enter_operands(100, 0);
    select_op((3 - m_op + 4) % 4);
    check("div_op", 32'(alu_op), 32'd3);
    issue();
    respond(2, 1'b1, 32'd0);
    check("div_err_code", 32'(err_code), 32'd1);
    check("div_err_state", 32'(state_out), 32'd6);
    check("div_err_valid", 32'(result_valid), 32'd0);
    pulse_confirm();
    check("err_ack_state", 32'(state_out), 32'd0);
    check("err_ack_code", 32'(err_code), 32'd0);

    // Timeout: no done ever arrives
    enter_operands(1, 2);
    select_op(0);
    issue();
    cycles = 0;
    busy_prev = busy;
    while (state_out == 3'd3 || state_out == 3'd4) begin
      if (cycles >= 40) break;
      busy_prev = busy;
      tick();
      cycles++;
    end
    check("timeout_cycles", 32'(cycles), 32'd16);
    check("timeout_state", 32'(state_out), 32'd6);
    check("timeout_code", 32'(err_code), 32'd2);
    check("timeout_busy_prev", 32'(busy_prev), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    pulse_confirm();

    // Chain with positive clamp: 500 * 4
    enter_operands(500, 4);
    select_op((2 - m_op + 4) % 4);
    issue();
    respond(1, 1'b0, alu_ref(m_op, m_a, m_b));
    check("mul_result", result, 32'd2000);
    pulse_op_next();
    check("chain_pos_a", 32'(alu_a), 32'd999);
    check("chain_pos_state", 32'(state_out), 32'd1);
    check("chain_pos_sel", 32'(entry_sel), 32'd1);
    pulse_clear();
    check("clear_idle_abort", 32'(alu_abort), 32'd0);
    check("clear_idle_state", 32'(state_out), 32'd0);

    // Chain with negative clamp: 500 * -4
    enter_operands(500, -4);
    select_op(0);
    issue();
    m_result = alu_ref(m_op, m_a, m_b);
    respond(0, 1'b0, m_result);
    check("mul_neg_result", result, 32'hFFFF_F830);
    pulse_op_next();
    check("chain_neg_a", 32'(alu_a), 32'h0000_FC19);
    check("chain_neg_state", 32'(state_out), 32'd1);
    pulse_clear();

    // Clear and confirm together in WAIT, then a stale done
    enter_operands(7, 8);
    select_op(1);
    issue();
    tick();
    check("pre_clear_wait", 32'(state_out), 32'd4);
    clear = 1'b1; confirm = 1'b1;
    tick();
    clear = 1'b0; confirm = 1'b0;
    check("clr_abort", 32'(alu_abort), 32'd1);
    check("clr_state", 32'(state_out), 32'd0);
    check("clr_valid", 32'(result_valid), 32'd0);
    check("clr_keep_a", 32'(alu_a), 32'd7);
    alu_done = 1'b1; alu_result = 32'h1234;
    tick();
    alu_done = 1'b0;
    check("abort_one_cycle", 32'(alu_abort), 32'd0);
    check("late_done_state", 32'(state_out), 32'd0);
    check("late_done_result", result, m_result);
    check("late_done_valid", 32'(result_valid), 32'd0);

    // Randomized calculations against the reference model
    for (int i = 0; i < 20; i++) begin
      a = int'($signed(16'($urandom_range(0, 65535))));
      b = int'($signed(16'($urandom_range(0, 65535))));
      n = $urandom_range(0, 5);
      new_op = (m_op + n) % 4;
      if (new_op == 3 && b == 0) b = 1;
      dly = $urandom_range(0, 6);
      enter_operands(a, b);
      select_op(n);
      issue();
      m_result = alu_ref(m_op, m_a, m_b);
      respond(dly, 1'b0, m_result);
      check("rnd_result", result, m_result);
      check("rnd_state", 32'(state_out), 32'd5);
      if ($urandom_range(0, 1) == 1) begin
        pulse_op_next();
        check("rnd_chain_a", 32'(alu_a), 32'(clamp_ref(m_result)));
        pulse_clear();
      end else begin
        pulse_confirm();
      end
      check("rnd_back_idle", 32'(state_out), 32'd0);
    end

    // Asynchronous reset in the middle of WAIT
    enter_operands(3, 4);
    select_op(1);
    issue();
    tick();
    #2 reset = 1'b0;
    #1;
    check("arst_state", 32'(state_out), 32'd0);
    check("arst_outs", {alu_start, alu_abort, entry_sel, result_valid, busy, err_code, alu_op}, 32'd0);
    check("arst_a_b", {alu_a, alu_b}, 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk) reset = 1'b1;
    m_op = 0;
    tick();
    check("arst_no_abort", 32'(alu_abort), 32'd0);
    check("arst_idle", 32'(state_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
